// File: rtl/nibble_adder_pkg.sv
// Shared types for the nibble-serial adder: FSM state encoding and slice width.
package nibble_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_cla4_cin.sv
// Combinational 4-bit carry-lookahead slice with carry-in; no latency, no flow control.
// c3 is the carry into the slice MSB, exposed for two's-complement overflow detection.
module cla4_cin (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       c3
);

   logic [3:0] g;
   logic [3:0] p;
   logic       c1;
   logic       c2;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum-of-products of g/p and cin, never rippled.
   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one 4-bit lookahead slice per cycle; SIGNED_OVF_EN adds the ovf output.
// Latency: accept edge plus WIDTH/4 RUN cycles; out_valid rises on the edge completing the last slice.
// Backpressure: in_ready low in RUN/DONE; DONE holds result until out_ready.
module nibble_serial_adder
   import nibble_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic               cout_q;
   logic [IDXW-1:0]    idx_q;
   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_co;
   logic               slice_c3;
   logic               last;
   logic               accept;

   assign accept = (state_q == IDLE) && in_valid;
   assign last   = (idx_q == IDXW'(NSLICE - 1));

   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx_q == IDXW'(k)) begin
            a_sl = a_q[k*SLICE_W +: SLICE_W];
            b_sl = b_q[k*SLICE_W +: SLICE_W];
         end
      end
   end

   cla4_cin u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .sum  (slice_s),
      .cout (slice_co),
      .c3   (slice_c3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) begin
               sum_q[k*SLICE_W +: SLICE_W] <= slice_s;
            end
         end
         carry_q <= slice_co;
         idx_q   <= idx_q + IDXW'(1);
         if (last) begin
            cout_q <= slice_co;
         end
      end
   end

`ifdef SIGNED_OVF_EN
   logic ovf_q;

   // Overflow is the carry into the top bit disagreeing with the carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last) begin
         ovf_q <= slice_c3 ^ slice_co;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_c3;
   assign unused_c3 = slice_c3;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): vector table, reset corner case and randomized traffic.
module tb_nibble_serial_adder;

   localparam int W  = 16;
   localparam int NS = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef SIGNED_OVF_EN
   logic         ovf;
`endif

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SIGNED_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      exp_t         e;
      int           hold;
   } vec_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_push  = 0;
   int   n_pop   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Scoreboard: every result handshake consumes one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_result: sum %0h with empty scoreboard", sum);
         end else begin
            e = sb.pop_front();
            n_pop++;
            check("sum", sum, e.s);
            check("cout", cout, e.co);
`ifdef SIGNED_OVF_EN
            check("ovf", ovf, e.ov);
`endif
         end
      end
   end

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] full;
      exp_t       e;
      full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      e.s  = full[W-1:0];
      e.co = full[W];
      e.ov = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      return e;
   endfunction

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input exp_t e, input int hold);
      int           lat;
      logic [W-1:0] s0;
      logic         c0;
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!in_ready) timeout("wait_in_ready");
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      cin       = c;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      sb.push_back(e);
      n_push++;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      check("busy_in_run", busy, 1);
      check("in_ready_in_run", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 4 * NS + 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) timeout("wait_out_valid");
      else check("latency", lat, NS);
      if (hold > 0) begin
         s0       = sum;
         c0       = cout;
         in_valid = 1'b1;
         a        = 16'h1111;
         b        = 16'h2222;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", sum, s0);
            check("hold_cout", cout, c0);
            check("hold_in_ready", in_ready, 0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      exp_t e;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         c;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}, 0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0}, 0};
      vecs[2] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}, 10};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, 0};
      vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0};
      vecs[5] = '{16'h0F0F, 16'h0101, 1'b1, '{16'h1011, 1'b0, 1'b0}, 2};
      vecs[6] = '{16'hABCD, 16'h1234, 1'b1, '{16'hBE02, 1'b0, 1'b0}, 0};
      vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, 1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, vecs[i].hold);
      end

      // Reset in the second RUN cycle discards the operation.
      in_valid  = 1'b1;
      a         = 16'h0F0F;
      b         = 16'h0101;
      cin       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_run_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0}, 0);

      for (int i = 0; i < 1000; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom_range(0, 1));
         e = model(x, y, c);
         run_op(x, y, c, e, int'($urandom_range(0, 3)));
      end

      check("no_lost_results", n_pop, n_push);
      check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
